// File: rtl/ahb_subordinate_mem.sv
// AHB-Lite subordinate with a word-addressed local memory, programmable
// wait states, byte-lane write strobes, read-after-write forwarding and
// the two-cycle ERROR response.
module ahb_subordinate_mem #(
    parameter int          ADDR_WIDTH  = 32,
    parameter int          DATA_WIDTH  = 32,
    parameter int          MEM_DEPTH   = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                    hclk,
    input  logic                    hreset,
    input  logic                    hsel,
    input  logic [ADDR_WIDTH-1:0]   haddr,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [2:0]              hburst,
    input  logic [3:0]              hprot,
    input  logic                    hmastlock,
    input  logic [DATA_WIDTH-1:0]   hwdata,
    input  logic [DATA_WIDTH/8-1:0] hwstrb,
    input  logic                    hready,
    output logic                    hreadyout,
    output logic                    hresp,
    output logic [DATA_WIDTH-1:0]   hrdata,
    output logic                    hexokay
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int NB    = DATA_WIDTH / 8;

    localparam logic [2:0] ST_READY = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_DONE  = 3'd2;
    localparam logic [2:0] ST_ERR1  = 3'd3;
    localparam logic [2:0] ST_ERR2  = 3'd4;

    logic [2:0]            state;
    logic [3:0]            wait_cnt;

    // Registered address-phase information for the data phase in flight
    logic                  dp_active;
    logic                  dp_write;
    logic                  dp_err;
    logic [IDX_W-1:0]      dp_idx;
    logic [NB-1:0]         dp_mask;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  accept;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  acc_err;
    logic [NB-1:0]         acc_mask;
    logic [IDX_W-1:0]      acc_idx;
    logic                  commit;
    logic [NB-1:0]         commit_strb;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] fwd_word;
    logic                  unused_ok;

    assign hreadyout = (state != ST_WAIT) && (state != ST_ERR1);
    assign hresp     = (state == ST_ERR1) || (state == ST_ERR2);
    assign hexokay   = 1'b0;
    assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0]};

    // Gating with our own hreadyout keeps a stray hready from re-accepting mid-phase
    assign accept      = hsel && hready && htrans[1] && hreadyout;
    assign offset      = haddr - ADDR_WIDTH'(BASE_ADDR);
    assign acc_idx     = offset[IDX_W+1:2];
    assign commit      = dp_active && hreadyout && !dp_err && dp_write;
    assign commit_strb = hwstrb & dp_mask;

    // Address-phase decode: error classification and byte-lane mask
    always_comb begin
        acc_err = 1'b0;
        if (hsize > 3'd2)
            acc_err = 1'b1;
        if ((hsize == 3'd1) && haddr[0])
            acc_err = 1'b1;
        if ((hsize == 3'd2) && (haddr[1:0] != 2'd0))
            acc_err = 1'b1;
        if (haddr < ADDR_WIDTH'(BASE_ADDR))
            acc_err = 1'b1;
        if (offset >= ADDR_WIDTH'(4 * MEM_DEPTH))
            acc_err = 1'b1;

        case (hsize)
            3'd0:    acc_mask = 4'b0001 << haddr[1:0];
            3'd1:    acc_mask = haddr[1] ? 4'b1100 : 4'b0011;
            default: acc_mask = 4'b1111;
        endcase
    end

    // Merge the committing write into the stored word; also the forwarding source
    always_comb begin
        wr_word = mem[dp_idx];
        for (int unsigned b = 0; b < NB; b++) begin
            if (commit_strb[b])
                wr_word[8*b +: 8] = hwdata[8*b +: 8];
        end
        if (commit && (dp_idx == acc_idx))
            fwd_word = wr_word;
        else
            fwd_word = mem[acc_idx];
    end

    // Memory array: cleared on reset, written on the edge that ends a write data phase
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset)
            mem <= '{default: '0};
        else if (commit)
            mem[dp_idx] <= wr_word;
    end

    // Transfer FSM, pending data-phase registers and registered read data
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state     <= ST_READY;
            wait_cnt  <= '0;
            dp_active <= 1'b0;
            dp_write  <= 1'b0;
            dp_err    <= 1'b0;
            dp_idx    <= '0;
            dp_mask   <= '0;
            hrdata    <= '0;
        end else begin
            case (state)
                ST_READY, ST_DONE, ST_ERR2: begin
                    if (accept) begin
                        dp_active <= 1'b1;
                        dp_write  <= hwrite;
                        dp_err    <= acc_err;
                        dp_idx    <= acc_idx;
                        dp_mask   <= acc_mask;
                        if (acc_err) begin
                            state  <= ST_ERR1;
                            hrdata <= '0;
                        end else if (WAIT_STATES > 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= 4'(WAIT_STATES - 1);
                        end else begin
                            state <= ST_READY;
                            if (!hwrite)
                                hrdata <= fwd_word;
                        end
                    end else begin
                        dp_active <= 1'b0;
                        state     <= ST_READY;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= ST_DONE;
                        if (!dp_write)
                            hrdata <= mem[dp_idx];
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: state <= ST_ERR2;
                default: state <= ST_READY;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_subordinate_mem.sv
// Directed bench for ahb_subordinate_mem: one zero-wait instance and one
// three-wait-state instance sharing the request bus, each with hready
// looped back from its own hreadyout.
module tb_ahb_subordinate_mem;

    logic        hclk = 1'b0;
    logic        hreset;
    logic        hsel0, hsel1;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic [3:0]  hwstrb;

    logic        ro0, resp0, ex0;
    logic [31:0] rd0;
    logic        ro1, resp1, ex1;
    logic [31:0] rd1;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic        sel_dut1;

    always #5 hclk = ~hclk;

    ahb_subordinate_mem #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256),
        .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)
    ) u_ws0 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel0), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata), .hwstrb(hwstrb),
        .hready(ro0), .hreadyout(ro0), .hresp(resp0), .hrdata(rd0), .hexokay(ex0)
    );

    ahb_subordinate_mem #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256),
        .BASE_ADDR(32'h0000_0000), .WAIT_STATES(3)
    ) u_ws3 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel1), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
        .hprot(hprot), .hmastlock(hmastlock), .hwdata(hwdata), .hwstrb(hwstrb),
        .hready(ro1), .hreadyout(ro1), .hresp(resp1), .hrdata(rd1), .hexokay(ex1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic addr_ph(input logic [31:0] a, input logic w, input logic [2:0] sz);
        hsel0  = !sel_dut1;
        hsel1  = sel_dut1;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        htrans = 2'b10;
    endtask

    task automatic idle_ph();
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    // Single zero-wait write on the WAIT_STATES=0 instance
    task automatic wr0(input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] d, input logic [3:0] s);
        addr_ph(a, 1'b1, sz);
        tick();
        hwdata = d;
        hwstrb = s;
        idle_ph();
        check_eq("wr0_ready", {31'd0, ro0}, 32'd1);
        tick();
    endtask

    // Single zero-wait word read with expected data
    task automatic rd0_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr_ph(a, 1'b0, 3'd2);
        tick();
        idle_ph();
        check_eq(tag, rd0, exp);
        check_eq({tag, "_resp"}, {31'd0, resp0}, 32'd0);
        tick();
    endtask

    // Errored transfer: two ERROR cycles, hreadyout low then high, hrdata zero
    task automatic err0(input string tag, input logic [31:0] a, input logic w, input logic [2:0] sz);
        addr_ph(a, w, sz);
        tick();
        hwdata = 32'hFFFF_FFFF;
        hwstrb = 4'hF;
        idle_ph();
        check_eq({tag, "_e1_resp"},  {31'd0, resp0}, 32'd1);
        check_eq({tag, "_e1_ready"}, {31'd0, ro0},   32'd0);
        check_eq({tag, "_e1_rdata"}, rd0,            32'd0);
        tick();
        check_eq({tag, "_e2_resp"},  {31'd0, resp0}, 32'd1);
        check_eq({tag, "_e2_ready"}, {31'd0, ro0},   32'd1);
        tick();
        check_eq({tag, "_after_resp"}, {31'd0, resp0}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        hreset = 1'b1; sel_dut1 = 1'b0;
        hsel0 = 1'b0; hsel1 = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd2; hburst = 3'd0; hprot = 4'h3; hmastlock = 1'b0;
        hwdata = '0; hwstrb = '0;
        tick(); tick();
        check_eq("rst_ready0", {31'd0, ro0}, 32'd1);
        check_eq("rst_resp0",  {31'd0, resp0}, 32'd0);
        check_eq("rst_rdata0", rd0, 32'd0);
        check_eq("rst_exokay0", {31'd0, ex0}, 32'd0);
        check_eq("rst_ready1", {31'd0, ro1}, 32'd1);
        hreset = 1'b0;
        tick();

        // Word write followed back-to-back by read of the same word
        addr_ph(32'h10, 1'b1, 3'd2);
        tick();
        hwdata = 32'hDEAD_BEEF; hwstrb = 4'hF;
        addr_ph(32'h10, 1'b0, 3'd2);
        check_eq("b2b_wr_ready", {31'd0, ro0}, 32'd1);
        tick();
        idle_ph();
        check_eq("b2b_rd_data",  rd0, 32'hDEAD_BEEF);
        check_eq("b2b_rd_ready", {31'd0, ro0}, 32'd1);
        check_eq("b2b_rd_resp",  {31'd0, resp0}, 32'd0);
        tick();

        // Byte and halfword lane masking, explicit strobes
        wr0(32'h20, 3'd2, 32'h1122_3344, 4'hF);
        wr0(32'h21, 3'd0, 32'hAAAA_AAAA, 4'hF);
        rd0_chk("byte_lane1", 32'h20, 32'h1122_AA44);
        wr0(32'h22, 3'd1, 32'h5566_7788, 4'hF);
        wr0(32'h24, 3'd2, 32'hA1B2_C3D4, 4'b0101);

        // Pipelined reads at one per cycle, then hrdata held over an idle cycle
        addr_ph(32'h20, 1'b0, 3'd2);
        tick();
        addr_ph(32'h24, 1'b0, 3'd2);
        check_eq("pipe_rd0", rd0, 32'h5566_AA44);
        tick();
        idle_ph();
        check_eq("pipe_rd1", rd0, 32'h00B2_00D4);
        tick();
        check_eq("rd_hold", rd0, 32'h00B2_00D4);
        check_eq("idle_ready", {31'd0, ro0}, 32'd1);

        // Read-after-write forwarding, full word then a single merged byte
        wr0(32'h8, 3'd2, 32'h1234_0000, 4'hF);
        addr_ph(32'h8, 1'b1, 3'd2);
        tick();
        hwdata = 32'h0000_FFFF; hwstrb = 4'hF;
        addr_ph(32'h8, 1'b0, 3'd2);
        tick();
        idle_ph();
        check_eq("fwd_word", rd0, 32'h0000_FFFF);
        tick();
        addr_ph(32'hB, 1'b1, 3'd0);
        tick();
        hwdata = 32'h7777_7777; hwstrb = 4'hF;
        addr_ph(32'h8, 1'b0, 3'd2);
        tick();
        idle_ph();
        check_eq("fwd_byte", rd0, 32'h7700_FFFF);
        tick();
        rd0_chk("fwd_stored", 32'h8, 32'h7700_FFFF);

        // Highest valid word, then error cases that must leave memory intact
        wr0(32'h3FC, 3'd2, 32'h0F0F_0F0F, 4'hF);
        rd0_chk("last_word", 32'h3FC, 32'h0F0F_0F0F);
        wr0(32'h0, 3'd2, 32'hCAFE_0000, 4'hF);
        err0("misalign_rd", 32'h2, 1'b0, 3'd2);
        err0("oob_wr", 32'h400, 1'b1, 3'd2);
        err0("dword_wr", 32'h10, 1'b1, 3'd3);
        err0("half_misalign_wr", 32'h11, 1'b1, 3'd1);
        rd0_chk("oob_untouched", 32'h0, 32'hCAFE_0000);
        rd0_chk("err_untouched", 32'h10, 32'hDEAD_BEEF);
        rd0_chk("last_untouched", 32'h3FC, 32'h0F0F_0F0F);

        // Three wait states: write then read of word 0
        hsel0 = 1'b0;
        sel_dut1 = 1'b1;
        addr_ph(32'h0, 1'b1, 3'd2);
        tick();
        hwdata = 32'h1357_9BDF; hwstrb = 4'hF;
        idle_ph();
        for (int i = 0; i < 3; i++) begin
            check_eq("ws_wr_wait", {31'd0, ro1}, 32'd0);
            tick();
        end
        check_eq("ws_wr_done", {31'd0, ro1}, 32'd1);
        check_eq("ws_wr_resp", {31'd0, resp1}, 32'd0);
        tick();
        addr_ph(32'h0, 1'b0, 3'd2);
        tick();
        idle_ph();
        for (int i = 0; i < 3; i++) begin
            check_eq("ws_rd_wait", {31'd0, ro1}, 32'd0);
            check_eq("ws_rd_old", rd1, 32'd0);
            tick();
        end
        check_eq("ws_rd_done", {31'd0, ro1}, 32'd1);
        check_eq("ws_rd_data", rd1, 32'h1357_9BDF);
        tick();

        // Reset during a wait-state write drops it and restores outputs at once
        addr_ph(32'h4, 1'b1, 3'd2);
        tick();
        hwdata = 32'hFFFF_FFFF; hwstrb = 4'hF;
        idle_ph();
        check_eq("rst_mid_wait", {31'd0, ro1}, 32'd0);
        #2;
        hreset = 1'b1;
        #1;
        check_eq("rst_async_ready", {31'd0, ro1}, 32'd1);
        check_eq("rst_async_resp", {31'd0, resp1}, 32'd0);
        check_eq("rst_async_rd0", rd0, 32'd0);
        hreset = 1'b0;
        tick();
        addr_ph(32'h8, 1'b1, 3'd2);
        tick();
        hwdata = 32'h2468_0ACE; hwstrb = 4'hF;
        idle_ph();
        repeat (3) tick();
        tick();
        addr_ph(32'h8, 1'b0, 3'd2);
        tick();
        idle_ph();
        repeat (3) tick();
        check_eq("post_rst_rd8", rd1, 32'h2468_0ACE);
        tick();
        addr_ph(32'h4, 1'b0, 3'd2);
        tick();
        idle_ph();
        repeat (3) tick();
        check_eq("dropped_write", rd1, 32'd0);
        check_eq("dropped_ready", {31'd0, ro1}, 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_subordinate_mem.md
# ahb_subordinate_mem

AHB-Lite subordinate (responder) with a local word-addressed register memory, programmable wait-state insertion and the two-cycle ERROR response. It is the RTL counterpart of the AHB manager-side driver and is the DUT-side endpoint the master agent drives and the slave agent monitors. It accepts pipelined address/data phases, applies byte-lane write strobes, and forwards a just-completed write into an immediately following read.

## Interface
Parameters:
- ADDR_WIDTH, 32, address bus width
- DATA_WIDTH, 32, data bus width; only 32 is supported, so the maximum legal hsize is WORD
- MEM_DEPTH, 256, number of DATA_WIDTH words
- BASE_ADDR, 32'h0000_0000, byte address of word 0
- WAIT_STATES, 0, hreadyout-low cycles inserted in every OKAY data phase of an active transfer (0–15)

Ports:
- hclk  in  1  clock; all logic is on its rising edge
- hreset  in  1  reset, asynchronous, active-high
- hsel  in  1  subordinate select
- haddr  in  ADDR_WIDTH  byte address
- htrans  in  2  IDLE/BUSY/NONSEQ/SEQ
- hwrite  in  1  1 = write
- hsize  in  3  transfer size (ahbHsizeEnum encoding)
- hburst  in  3  burst type; accepted, not checked
- hprot  in  4  protection; accepted, ignored
- hmastlock  in  1  accepted, ignored
- hwdata  in  DATA_WIDTH  write data (data phase)
- hwstrb  in  DATA_WIDTH/8  write strobes (data phase)
- hready  in  1  combined bus ready
- hreadyout  out  1  this subordinate's ready
- hresp  out  1  0 = OKAY, 1 = ERROR
- hrdata  out  DATA_WIDTH  read data
- hexokay  out  1  constant 0; exclusive access is not supported

## Operation
- Address phase is accepted when hsel & hready & htrans[1] at a rising edge. The block registers addr, write, size and error flag.
- hsel with IDLE or BUSY and hready high: next data phase is zero-wait OKAY, with no memory access.
- Error check at acceptance; any of the following errors the transfer:
  - hsize > WORD
  - misalignment: HALFWORD with addr[0]=1, or WORD with addr[1:0]≠0
  - addr < BASE_ADDR, or addr − BASE_ADDR ≥ 4·MEM_DEPTH
- An errored transfer never modifies memory and returns hrdata=0.
- Lane mask: BYTE enables lane addr[1:0]; HALFWORD enables lanes {addr[1],0} and {addr[1],1}; WORD enables all four lanes.
- Write commit: effective strobe = hwstrb & lane mask. The write commits on the edge that ends the data phase (hreadyout=1).
- Reads: hrdata returns the full addressed word. Unenabled lanes still carry memory contents.
- Read-after-write forwarding: a read accepted on the same edge a write to the same word commits returns the merged (post-write) bytes.
- FSM states and transitions:
  - READY: hreadyout=1.
  - Accept with error → ERR1.
  - Accept with WAIT_STATES>0 → WAIT (counter loaded with WAIT_STATES−1).
  - Accept otherwise → READY, with the data phase completing next cycle.
  - WAIT: hreadyout=0; counter decrements; at 0 → DONE.
  - DONE: hreadyout=1; completes OKAY; may accept the next address phase and then branches as READY does.
  - ERR1: hresp=1, hreadyout=0 → ERR2.
  - ERR2: hresp=1, hreadyout=1; may accept the next address phase.
- Address phases presented while hready is low are ignored.

## Timing
- Reset values: hreadyout=1, hresp=0, hrdata=0, hexokay=0, FSM=READY, wait counter=0, all memory words=0.
- Read latency: hrdata is valid in the cycle where hreadyout=1 ends the data phase, i.e. 1+WAIT_STATES cycles after the address phase. hrdata is registered and held until the next completed read.
- The write data phase samples hwdata/hwstrb only on the completing edge.
- ERROR is always exactly 2 cycles. It is never preceded by wait states.
- Back-to-back pipelined transfers (NONSEQ followed by SEQ) with WAIT_STATES=0 sustain one transfer per cycle.
- Reset asserted mid-transfer aborts it: the pending write is dropped and outputs return to reset values asynchronously.

## Test plan
- WAIT_STATES=0: WORD write 0xDEADBEEF @0x10, then read @0x10 next cycle → hrdata=0xDEADBEEF, hreadyout never low, hresp=0.
- BYTE write 0xAA @0x21 (hwstrb=4'b1111) over word 0x11223344 → read @0x20 returns 0x1122AA44.
- WAIT_STATES=3: read @0x0 → hreadyout low for 3 cycles, then high with data.
- WORD read @0x02 → hresp=1 for 2 cycles, hreadyout 0 then 1. Repeat with addr 0x400 (out of range) and hsize=DOUBLEWORD; memory is unchanged afterwards.
- Write 0x0000FFFF @0x8 followed back-to-back by read @0x8 → forwarded 0x0000FFFF. Assert hreset during a wait-state write → word stays at 0 and hreadyout=1 immediately.
